adder_batch_master: RTL

Requesting side of the single-precision adder handshake. On a start pulse it streams up to 2^DEPTH_LOG2 operand pairs from a dual-output operand RAM into `adder_control_system`, one request per cycle. Each request is a one-cycle `sta` with `x`/`y`/`add_sub`. The block collects each `xy` on the matching `done_sig` and writes it to a result RAM in issue order. It sits between the solver's vector-op scheduler and the shared adder instance.

---
 rtl/adder_batch_master_pkg.sv | 27 ++
 rtl/adder_req_tracker.sv | 79 +++++++
 rtl/adder_batch_master.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/adder_batch_master_pkg.sv
// Shared constants for the adder batch master: data width, adder latency,
// FSM state encoding and the adder IP's add/subtract mode polarity.
package adder_batch_master_pkg;

    // IEEE-754 single-precision word width.
    localparam int SINGLE = 32;

    // Default sta -> done_sig latency of the shared adder instance.
    localparam int ADD_LAT_DEFAULT = 7;

    // Batch FSM encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // The adder IP adds when its mode bit is high, which is the inverse of
    // the scheduler's op_sub request bit.
    localparam logic ADD_POL = 1'b1;
    localparam logic SUB_POL = 1'b0;

    // Translate the scheduler's op_sub into the adder IP mode bit.
    function automatic logic mode_bit(input logic op_sub);
        return op_sub ? SUB_POL : ADD_POL;
    endfunction

endpackage

// File: rtl/adder_req_tracker.sv
// Tracks adder requests in flight: outstanding counter, detection of a
// done_sig that has no matching request, and the drain-phase watchdog.
module adder_req_tracker
    import adder_batch_master_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADD_LAT    = ADD_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,      // new batch accepted: forget any stale state
    input  logic add_sta,
    input  logic add_done,
    input  logic pipe_busy,  // operand read/register stages still hold work
    input  logic drain,      // FSM is waiting for the tail of the batch
    output logic done_ok,    // add_done that matches an outstanding request
    output logic idle_ok,    // nothing in flight, no write pending
    output logic err_pulse,  // underflow or watchdog expiry this cycle
    output logic timeout     // watchdog expiry this cycle
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int WD_W  = $clog2(ADD_LAT + 3);
    // Expiry fires on the (ADD_LAT+3)th consecutive silent cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ADD_LAT + 2);

    logic [CNT_W-1:0] outstanding;
    logic [WD_W-1:0]  wd_cnt;
    logic             underflow;
    logic             wd_run;

    // Classify this cycle's adder traffic and derive the status flags.
    always_comb begin
        // NOTE: every output of this block gets a value up front so no path
        // can leave one unassigned and infer a latch.
        underflow = 1'b0;
        done_ok   = 1'b0;
        wd_run    = 1'b0;
        timeout   = 1'b0;
        idle_ok   = 1'b0;
        err_pulse = 1'b0;
        // A done with nothing outstanding cannot belong to any request, even
        // if a new request is launched in the same cycle.
        underflow = add_done && (outstanding == '0);
        done_ok   = add_done && !underflow;
        wd_run    = drain && (outstanding != '0) && !add_done;
        timeout   = wd_run && (wd_cnt == WD_LAST);
        // A done this cycle means a write next cycle, so not idle yet.
        idle_ok   = (outstanding == '0) && !add_done && !pipe_busy;
        err_pulse = underflow || timeout;
    end

    // Outstanding-request counter; cleared on a new batch or an abort.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!rst) begin
            outstanding <= '0;
        end else if (clear || timeout) begin
            outstanding <= '0;
        end else if (add_sta && !done_ok) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!add_sta && done_ok) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    // Watchdog: counts consecutive drain cycles with requests pending but no done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (clear || timeout || !wd_run) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

endmodule

// File: rtl/adder_batch_master.sv
// Requesting side of the single-precision adder handshake: streams a batch of
// operand pairs from the operand RAM into the shared adder, one per cycle, and
// writes each result to the result RAM in completion order.
module adder_batch_master
    import adder_batch_master_pkg::*;
#(
    parameter int WIDTH      = SINGLE,
    parameter int DEPTH_LOG2 = 4,
    parameter int ADD_LAT    = ADD_LAT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DEPTH_LOG2:0]   len,
    input  logic                  op_sub,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rd_en,
    output logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic [WIDTH-1:0]      rd_data_a,
    input  logic [WIDTH-1:0]      rd_data_b,
    output logic                  add_sta,
    output logic                  add_sub,
    output logic [WIDTH-1:0]      add_x,
    output logic [WIDTH-1:0]      add_y,
    input  logic                  add_done,
    input  logic [WIDTH-1:0]      add_xy,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    localparam int LEN_W = DEPTH_LOG2 + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << DEPTH_LOG2);

    logic [1:0]            state;
    logic [DEPTH_LOG2-1:0] last_addr;
    logic                  rd_valid;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  accept;
    logic                  len_over;
    logic [LEN_W-1:0]      len_eff;
    logic                  done_ok;
    logic                  idle_ok;
    logic                  err_pulse;
    logic                  timeout;

    // Start acceptance and length clamping.
    always_comb begin
        accept   = start && (state == ST_IDLE);
        len_over = len > MAX_LEN;
        len_eff  = len_over ? MAX_LEN : len;
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FINISH);

    adder_req_tracker #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ADD_LAT    (ADD_LAT)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .add_sta   (add_sta),
        .add_done  (add_done),
        .pipe_busy (rd_valid || add_sta),
        .drain     (state == ST_DRAIN),
        .done_ok   (done_ok),
        .idle_ok   (idle_ok),
        .err_pulse (err_pulse),
        .timeout   (timeout)
    );

    // Batch FSM and operand read sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            last_addr <= '0;
            add_sub   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        add_sub   <= mode_bit(op_sub);
                        last_addr <= DEPTH_LOG2'(len_eff - LEN_W'(1));
                        rd_addr   <= '0;
                        if (len_eff == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state <= ST_ISSUE;
                            rd_en <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rd_addr == last_addr) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + DEPTH_LOG2'(1);
                    end
                end
                ST_DRAIN: begin
                    if (timeout || idle_ok) begin
                        state <= ST_FINISH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flag; a new batch restarts it from its own length check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= len_over || err_pulse;
        end else if (err_pulse) begin
            err <= 1'b1;
        end
    end

    // Operand stage: RAM data arrives the cycle after rd_en and is registered
    // into the adder request, so add_sta trails each read by two cycles.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the operand and result data registers are reset as well,
        // because every output must read 0 while reset is applied.
        if (!rst) begin
            rd_valid <= 1'b0;
            add_sta  <= 1'b0;
            add_x    <= '0;
            add_y    <= '0;
        end else begin
            rd_valid <= rd_en;
            add_sta  <= rd_valid;
            if (rd_valid) begin
                add_x <= rd_data_a;
                add_y <= rd_data_b;
            end
        end
    end

    // Result stage: each matched add_done becomes a result RAM write one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_ptr  <= '0;
        end else begin
            wr_en <= done_ok;
            if (done_ok) begin
                wr_addr <= wr_ptr;
                wr_data <= add_xy;
            end
            if (accept) begin
                wr_ptr <= '0;
            end else if (done_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
        end
    end

endmodule
